// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I opcode, funct3 and LSU state definitions
// Contents: OP_LOAD/OP_STORE opcodes, F3_* access-width codes,
// lsu_state_t FSM encoding, funct3 legality helpers.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend and store replication
// Ports: funct3 (access width/sign), offset (byte lane), store_data,
// rdata (bus read word) -> wstrb, wdata (lane-replicated), load_data.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed lane down to bit 0 before extending.
    shifted   = rdata >> {offset, 3'b000};
    load_data = 32'd0;
    wstrb     = 4'b0000;
    wdata     = 32'd0;

    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      F3_W:    load_data = rdata;
      default: load_data = 32'd0;
    endcase

    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with bypass for non-memory results
// Ports: clk, rst (sync active-high); in_valid/in_ready handshake with
// opcode, funct3, addr, store_data, rd_idx; bus mem_req/mem_we/mem_addr/
// mem_wdata/mem_wstrb with mem_ack/mem_rdata; writeback wb_valid/wb_rd/
// wb_data; fault pulse.
// Option: LSU_MISALIGN_TRAP_EN defined -> misaligned H/W accesses fault;
// undefined -> they are aligned down and proceed.
module lsu
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_idx,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault
);

  lsu_state_t state, state_n;

  logic        load_r, store_r, fault_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, sdata_r, rdata_r;
  logic [4:0]  rd_r;

  logic        is_load, is_store, is_mem, f3_ok, mis_trap, dec_fault, accept;
  logic [31:0] eff_addr;

  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  // Decode of the incoming instruction, used only at accept.
  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_mem   = is_load || is_store;
    f3_ok    = is_load ? load_f3_legal(funct3) : store_f3_legal(funct3);
    // Memory addresses are pulled to natural alignment; bypass values pass raw.
    eff_addr = addr;
    if (is_mem) begin
      if (funct3 == F3_H || funct3 == F3_HU)
        eff_addr = {addr[31:1], 1'b0};
      else if (funct3 == F3_W)
        eff_addr = {addr[31:2], 2'b00};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_trap = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                    ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
  assign mis_trap = 1'b0;
`endif

  assign dec_fault = is_mem && (!f3_ok || mis_trap);
  assign accept    = in_valid && (state == LSU_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      load_r  <= 1'b0;
      store_r <= 1'b0;
      fault_r <= 1'b0;
      f3_r    <= 3'd0;
      addr_r  <= 32'd0;
      sdata_r <= 32'd0;
      rd_r    <= 5'd0;
      rdata_r <= 32'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        load_r  <= is_load;
        store_r <= is_store;
        fault_r <= dec_fault;
        f3_r    <= funct3;
        addr_r  <= eff_addr;
        sdata_r <= store_data;
        rd_r    <= rd_idx;
      end
      if (state == LSU_BUS && mem_ack)
        rdata_r <= mem_rdata;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      LSU_IDLE: begin
        if (in_valid)
          state_n = (is_mem && !dec_fault) ? LSU_BUS : LSU_DONE;
      end
      LSU_BUS:  if (mem_ack) state_n = LSU_DONE;
      LSU_DONE: state_n = LSU_IDLE;
      default:  state_n = LSU_IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3     (f3_r),
    .offset     (addr_r[1:0]),
    .store_data (sdata_r),
    .rdata      (rdata_r),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // Bus fields are only driven while the request is up; they come from
  // registers written at accept, so they cannot move during a request.
  always_comb begin
    in_ready  = (state == LSU_IDLE);
    mem_req   = (state == LSU_BUS);
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'b0000;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    fault     = 1'b0;
    if (state == LSU_BUS) begin
      mem_addr = {addr_r[31:2], 2'b00};
      if (store_r) begin
        mem_we    = 1'b1;
        mem_wdata = al_wdata;
        mem_wstrb = al_wstrb;
      end
    end
    if (state == LSU_DONE) begin
      fault = fault_r;
      if (!fault_r && !store_r) begin
        wb_valid = 1'b1;
        wb_rd    = rd_r;
        wb_data  = load_r ? al_load : addr_r;
      end
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream ALU result valid.
- in_ready  output  1  lsu can accept.
- opcode  input  7  RV32I opcode of the instruction.
- funct3  input  3  RV32I funct3 of the instruction.
- addr  input  32  ALU result; effective address for LOAD/STORE, else the writeback value.
- store_data  input  32  rs2 value for stores.
- rd_idx  input  5  destination register index.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word-aligned address.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte strobes.
- mem_ack  input  1  bus completion, one-cycle pulse.
- mem_rdata  input  32  read word, valid with mem_ack.
- wb_valid  output  1  writeback pulse.
- wb_rd  output  5  writeback index.
- wb_data  output  32  writeback value.
- fault  output  1  misaligned or illegal-funct3 pulse.

Function
REQ-002 The FSM SHALL have exactly three states, IDLE, BUS and DONE; in_ready SHALL be 1 only in IDLE.
REQ-003 Accept occurs on the cycle with in_valid&&in_ready; all inputs SHALL be registered at accept.
REQ-004 Non-LOAD/STORE opcodes SHALL bypass the bus: IDLE->DONE; wb_valid=1, wb_data=addr, wb_rd=rd_idx in cycle T+1 (T = accept cycle).
REQ-005 LOAD (0000011) and STORE (0100011) SHALL go IDLE->BUS; mem_req=1 from T+1 until the cycle mem_ack is sampled 1, inclusive.
REQ-006 mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be held stable while mem_req=1; mem_addr={addr[31:2],2'b00}.
REQ-007 On mem_ack the FSM SHALL go BUS->DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-008 LOAD in DONE SHALL give wb_valid=1 with wb_data extracted from mem_rdata captured at ack:
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
- LW: full word.
- Lane selected by addr[1:0].
REQ-009 STORE SHALL produce no wb_valid.
REQ-010 Store strobes and data SHALL be:
- SB: wstrb=4'b0001<<addr[1:0], data byte replicated x4.
- SH: wstrb=4'b0011<<addr[1:0], halfword replicated x2.
- SW: wstrb=4'b1111.
REQ-011 Illegal funct3 (LOAD 011/110/111; STORE other than 000/001/010) SHALL skip the bus: IDLE->DONE, fault=1, wb_valid=0.
REQ-012 mem_ack outside BUS SHALL be ignored.
REQ-013 wb_valid and fault SHALL be single-cycle pulses; wb_rd=0 SHALL be reported unchanged.

Reset
REQ-014 rst SHALL force IDLE and all outputs to 0 on the next edge, except in_ready which SHALL be 1.
REQ-015 rst during BUS SHALL drop mem_req on the next edge; a late mem_ack after reset SHALL be ignored.
REQ-016 rst coincident with mem_ack or in_valid SHALL take priority.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN:
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL take IDLE->DONE with fault=1, no bus, no wb_valid.
- Undefined: such accesses SHALL proceed with addr aligned down to natural alignment, and fault SHALL never assert for misalignment.

Structure
REQ-018 Opcode constants (LOAD, STORE), funct3 width codes and FSM state encodings SHALL live in the shared rv32 package/header that the ALU also includes.
REQ-019 Lane extract/extend and strobe/data replication SHALL be one combinational sub-module, lsu_align; the FSM and registers SHALL stay in lsu.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Bypass: opcode 0110011, addr 2034324, rd_idx 5 -> wb_valid at T+1, wb_data 2034324, wb_rd 5, no mem_req.
- LW: addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> mem_req held 3 cycles, wb_data 0xDEADBEEF one cycle after ack.
- LB/LBU: addr 0x103, rdata 0x80123456 -> LB wb_data 0xFFFFFF80; LBU wb_data 0x00000080.
- SH: addr 0x102, store_data 0x1234ABCD -> mem_addr 0x100, wstrb 4'b1100, wdata 0xABCDABCD, mem_we 1, no wb_valid.
- LW at addr 0x101 -> with macro: fault pulse, no mem_req; without macro: mem_addr 0x100, normal load.
- rst asserted in BUS, ack one cycle later -> mem_req 0 after the edge, in_ready 1, no wb_valid, no fault.
